// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU sharing controller: ALU select codes, FSM
// state encodings and flag bit positions within the captured flags word.
package alu_share_ctrl_pkg;

    localparam int FLAG_W    = 3;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_COUT = 0;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic zero,
                                                     input logic ovf,
                                                     input logic cout);
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_ZERO] = zero;
        f[FLAG_OVF]  = ovf;
        f[FLAG_COUT] = cout;
        return f;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response channels between the two client blocks and the ALU
// sharing controller. Clients use the master modport, the controller slave.
interface alu_share_ctrl_if
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [SEL_W-1:0]  req0_op;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [SEL_W-1:0]  req1_op;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [WIDTH-1:0]  rsp0_result;
    logic [FLAG_W-1:0] rsp0_flags;

    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp1_result;
    logic [FLAG_W-1:0] rsp1_flags;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_flags
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On contention the requester that was not
// served last wins; a lone requester always wins.
module rr_arbiter2 (
    input  logic [1:0] vld_i,
    input  logic       last_grant_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_vld_o = |vld_i;
        gnt_id_o  = 1'b0;
        unique case (vld_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_grant_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters: arbitrate,
// drive registered operands for one cycle, capture result, hand it back.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus,
    output logic [SEL_W-1:0] alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e            state_q, state_d;
    logic              gnt_id_q, gnt_id_d;
    logic              last_grant_q, last_grant_d;
    logic [SEL_W-1:0]  alu_s_q, alu_s_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0] req_vld;
    logic       gnt_vld;
    logic       gnt_id;
    logic       accept;
    logic       rsp_hs;

    assign req_vld = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .vld_i        (req_vld),
        .last_grant_i (last_grant_q),
        .gnt_vld_o    (gnt_vld),
        .gnt_id_o     (gnt_id)
    );

    // Ready is only offered to the current winner, so it never rises without valid.
    assign accept         = (state_q == IDLE) && gnt_vld;
    assign bus.req0_ready = accept && !gnt_id;
    assign bus.req1_ready = accept &&  gnt_id;

    assign bus.rsp0_valid  = (state_q == RESP) && !gnt_id_q;
    assign bus.rsp1_valid  = (state_q == RESP) &&  gnt_id_q;
    assign bus.rsp0_result = result_q;
    assign bus.rsp1_result = result_q;
    assign bus.rsp0_flags  = flags_q;
    assign bus.rsp1_flags  = flags_q;

    assign rsp_hs = (state_q == RESP) && (gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready);

    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;
        alu_s_d      = alu_s_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        result_d     = result_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_s_d  = gnt_id ? bus.req1_op : bus.req0_op;
                    alu_a_d  = gnt_id ? bus.req1_a  : bus.req0_a;
                    alu_b_d  = gnt_id ? bus.req1_b  : bus.req0_b;
                    gnt_id_d = gnt_id;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                flags_d  = pack_flags(alu_zero, alu_overflow, alu_cout);
                state_d  = RESP;
            end
            RESP: begin
                // Fairness pointer only moves once the response is actually taken.
                if (rsp_hs) begin
                    last_grant_d = gnt_id_q;
                    cnt_d        = cnt_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            alu_s_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            last_grant_q <= last_grant_d;
            alu_s_q      <= alu_s_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            cnt_q        <= cnt_d;
        end
    end

    assign alu_s    = alu_s_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign busy     = (state_q != IDLE);
    assign op_count = cnt_q;

endmodule
